// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift/add multiplier
// and restoring divider, feeding a valid/ready output register.
module execute_stage #(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] immx,
    input  logic        isimmediate,
    input  logic        isld,
    input  logic        isst,
    input  logic        iswb,
    input  logic [3:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] aluresult,
    output logic [31:0] op2_out,
    output logic        isld_out,
    output logic        isst_out,
    output logic        iswb_out,
    output logic [3:0]  rd_out,
    output logic        flag_e,
    output logic        flag_gt
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
        OP_MOD = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_NOT = 4'd7,
        OP_MOV = 4'd8, OP_LSL = 4'd9, OP_LSR = 4'd10, OP_ASR = 4'd11,
        OP_CMP = 4'd12
    } op_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [3:0]  m_op;
    logic [31:0] m_a;      // multiplicand (shifted left each iteration)
    logic [31:0] m_b;      // multiplier (shifted right) or divisor
    logic [31:0] m_acc;    // product or partial remainder
    logic [31:0] m_q;      // dividend bits shifting out / quotient bits shifting in
    logic [31:0] m_op2;
    logic [3:0]  m_rd;
    logic        m_ld, m_st, m_wb;

    logic [31:0] opb;
    logic [31:0] alu_res;
    logic [31:0] multi_res;
    logic [32:0] rem_sh, rem_sub;
    logic        div_ge;
    logic        accept, is_multi, load_single, load_multi, last_iter;

    assign opb         = isimmediate ? immx : op2;
    assign in_ready    = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign is_multi    = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_MOD);
    assign load_single = accept && !is_multi;
    assign load_multi  = (state == S_DONE) && (!out_valid || out_ready);
    assign last_iter   = (cnt == 6'(DIV_ITERS - 1));

    // One restoring-division step; a zero divisor naturally yields an
    // all-ones quotient and leaves the dividend as the remainder.
    assign rem_sh  = {m_acc, m_q[31]};
    assign rem_sub = rem_sh - {1'b0, m_b};
    assign div_ge  = (rem_sh >= {1'b0, m_b});

    // Single-cycle ALU result; codes 13-15 fall through to mov
    always_comb begin
        alu_res = opb;
        case (alu_op)
            OP_ADD: alu_res = op1 + opb;
            OP_SUB: alu_res = op1 - opb;
            OP_AND: alu_res = op1 & opb;
            OP_OR:  alu_res = op1 | opb;
            OP_NOT: alu_res = ~opb;
            OP_LSL: alu_res = op1 << opb[4:0];
            OP_LSR: alu_res = op1 >> opb[4:0];
            OP_ASR: alu_res = 32'($signed(op1) >>> opb[4:0]);
            OP_CMP: alu_res = '0;
            OP_MUL, OP_DIV, OP_MOD: alu_res = '0;
            default: alu_res = opb;
        endcase
    end

    // Select the finished multi-cycle result
    always_comb begin
        multi_res = m_acc;
        if (m_op == OP_DIV)
            multi_res = m_q;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && is_multi) state_nx = S_BUSY;
            S_BUSY: if (last_iter)          state_nx = S_DONE;
            S_DONE: if (load_multi)         state_nx = S_IDLE;
            default:                        state_nx = S_IDLE;
        endcase
    end

    // Multi-cycle operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            m_op  <= '0;
            m_a   <= '0;
            m_b   <= '0;
            m_acc <= '0;
            m_q   <= '0;
            m_op2 <= '0;
            m_rd  <= '0;
            m_ld  <= 1'b0;
            m_st  <= 1'b0;
            m_wb  <= 1'b0;
        end else if (accept && is_multi) begin
            cnt   <= '0;
            m_op  <= alu_op;
            m_a   <= op1;
            m_b   <= opb;
            m_acc <= '0;
            m_q   <= op1;
            m_op2 <= op2;
            m_rd  <= rd;
            m_ld  <= isld;
            m_st  <= isst;
            m_wb  <= iswb;
        end else if (state == S_BUSY) begin
            cnt <= cnt + 6'd1;
            if (m_op == OP_MUL) begin
                m_acc <= m_acc + (m_b[0] ? m_a : '0);
                m_a   <= m_a << 1;
                m_b   <= m_b >> 1;
            end else begin
                m_acc <= div_ge ? rem_sub[31:0] : rem_sh[31:0];
                m_q   <= {m_q[30:0], div_ge};
            end
        end
    end

    // Output register: load from ALU or finished unit, else drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            aluresult <= '0;
            op2_out   <= '0;
            isld_out  <= 1'b0;
            isst_out  <= 1'b0;
            iswb_out  <= 1'b0;
            rd_out    <= '0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            aluresult <= alu_res;
            op2_out   <= op2;
            isld_out  <= isld;
            isst_out  <= isst;
            iswb_out  <= iswb;
            rd_out    <= rd;
        end else if (load_multi) begin
            out_valid <= 1'b1;
            aluresult <= multi_res;
            op2_out   <= m_op2;
            isld_out  <= m_ld;
            isst_out  <= m_st;
            iswb_out  <= m_wb;
            rd_out    <= m_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Compare flags update only on an accepted cmp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_e  <= 1'b0;
            flag_gt <= 1'b0;
        end else if (accept && (alu_op == OP_CMP)) begin
            flag_e  <= (op1 == opb);
            flag_gt <= ($signed(op1) > $signed(opb));
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, immx;
    logic        isimmediate, isld, isst, iswb;
    logic [3:0]  rd;
    logic        out_valid, out_ready;
    logic [31:0] aluresult, op2_out;
    logic        isld_out, isst_out, iswb_out;
    logic [3:0]  rd_out;
    logic        flag_e, flag_gt;

    int errors = 0;
    int checks = 0;

    execute_stage #(.DIV_ITERS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .immx(immx),
        .isimmediate(isimmediate), .isld(isld), .isst(isst), .iswb(iswb), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluresult(aluresult), .op2_out(op2_out),
        .isld_out(isld_out), .isst_out(isst_out), .iswb_out(iswb_out), .rd_out(rd_out),
        .flag_e(flag_e), .flag_gt(flag_gt)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic useimm,
                         input logic ld, input logic st, input logic wb, input logic [3:0] r);
        in_valid    = 1'b1;
        alu_op      = op;
        op1         = a;
        op2         = b;
        immx        = imm;
        isimmediate = useimm;
        isld        = ld;
        isst        = st;
        iswb        = wb;
        rd          = r;
    endtask

    // Accept a multi-cycle op, wait 32 iterations, check result at T+33
    task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic useimm,
                             input logic [31:0] exp);
        logic stray;
        issue(op, a, b, imm, useimm, 1'b0, 1'b0, 1'b1, 4'd6);
        step();
        in_valid = 1'b0;
        stray = in_ready | out_valid;
        repeat (32) begin
            step();
            stray = stray | in_ready | out_valid;
        end
        chk({tag, "_busy"}, 32'(stray), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, aluresult, exp);
        chk({tag, "_rd"}, 32'(rd_out), 32'd6);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [3:0]  tv_op  [7];
    logic [31:0] tv_a   [7];
    logic [31:0] tv_b   [7];
    logic [31:0] tv_exp [7];

    initial begin
        logic stray;
        logic [31:0] held_res, held_op2;

        rst_n = 1'b0;
        out_ready = 1'b1;
        issue(4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        in_valid = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_aluresult", aluresult, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", {30'd0, flag_e, flag_gt}, 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back single-cycle stream
        issue(4'd0, 32'h7FFFFFFF, 32'h0, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_res", aluresult, 32'h80000000);
        chk("add_rd", 32'(rd_out), 32'd1);
        issue(4'd1, 32'h0, 32'd1, 32'd77, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        chk("sub_res", aluresult, 32'hFFFFFFFF);
        chk("sub_op2", op2_out, 32'd1);
        issue(4'd11, 32'h80000000, 32'h0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        chk("asr_res", aluresult, 32'hF8000000);
        chk("asr_valid", 32'(out_valid), 32'd1);

        // Miscellaneous single-cycle ops through the immediate path
        tv_op[0] = 4'd5;  tv_a[0] = 32'h0000F0F0; tv_b[0] = 32'h0000FF00; tv_exp[0] = 32'h0000F000;
        tv_op[1] = 4'd6;  tv_a[1] = 32'h0000F0F0; tv_b[1] = 32'h0000FF00; tv_exp[1] = 32'h0000FFF0;
        tv_op[2] = 4'd7;  tv_a[2] = 32'h12345678; tv_b[2] = 32'h0F0F0F0F; tv_exp[2] = 32'hF0F0F0F0;
        tv_op[3] = 4'd9;  tv_a[3] = 32'h00000001; tv_b[3] = 32'd33;       tv_exp[3] = 32'h00000002;
        tv_op[4] = 4'd10; tv_a[4] = 32'h80000000; tv_b[4] = 32'd4;        tv_exp[4] = 32'h08000000;
        tv_op[5] = 4'd15; tv_a[5] = 32'hDEADBEEF; tv_b[5] = 32'h12345678; tv_exp[5] = 32'h12345678;
        tv_op[6] = 4'd8;  tv_a[6] = 32'hDEADBEEF; tv_b[6] = 32'hA5A5A5A5; tv_exp[6] = 32'hA5A5A5A5;
        for (int i = 0; i < 7; i++) begin
            issue(tv_op[i], tv_a[i], 32'h0, tv_b[i], 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
            step();
            chk($sformatf("misc_op%0d", tv_op[i]), aluresult, tv_exp[i]);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Multiply, divide, modulo
        run_multi("mul", 4'd2, 32'h00010000, 32'h00010001, 32'h0, 1'b0, 32'h00010000);
        run_multi("div", 4'd3, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14);
        run_multi("mod", 4'd4, 32'd100, 32'd7, 32'h0, 1'b0, 32'd2);
        run_multi("div0", 4'd3, 32'd5, 32'd9, 32'd0, 1'b1, 32'hFFFFFFFF);
        run_multi("mod0", 4'd4, 32'd5, 32'd0, 32'd9, 1'b0, 32'd5);
        step();

        // Backpressure on a load
        out_ready = 1'b0;
        issue(4'd0, 32'h100, 32'h0000CAFE, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        step();
        chk("bp_res", aluresult, 32'h104);
        chk("bp_op2", op2_out, 32'h0000CAFE);
        chk("bp_ctl", {28'd0, isld_out, isst_out, iswb_out, 1'b0}, 32'b1010);
        chk("bp_rd", 32'(rd_out), 32'd3);
        held_res = aluresult;
        held_op2 = op2_out;
        issue(4'd8, 32'h0, 32'h0, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
        stray = 1'b0;
        repeat (5) begin
            step();
            stray = stray | in_ready | !out_valid | (aluresult != held_res)
                    | (op2_out != held_op2) | !isld_out | (rd_out != 4'd3);
        end
        chk("bp_hold", 32'(stray), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_res", aluresult, 32'h55);
        chk("bp_next_ctl", {28'd0, isld_out, isst_out, iswb_out, 1'b0}, 32'b0100);
        chk("bp_next_rd", 32'(rd_out), 32'd5);

        // Compare and flag persistence
        issue(4'd12, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk("cmp1_flags", {30'd0, flag_e, flag_gt}, 32'b00);
        chk("cmp1_res", aluresult, 32'd0);
        chk("cmp1_valid", 32'(out_valid), 32'd1);
        issue(4'd12, 32'd7, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk("cmp2_flags", {30'd0, flag_e, flag_gt}, 32'b10);
        issue(4'd0, 32'd7, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        step();
        chk("add_keep_flags", {30'd0, flag_e, flag_gt}, 32'b10);
        chk("add_after_cmp", aluresult, 32'd14);
        issue(4'd12, 32'd5, 32'h0, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk("cmp3_flags", {30'd0, flag_e, flag_gt}, 32'b01);
        in_valid = 1'b0;
        step();

        // Reset while a divide is in flight
        issue(4'd3, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("rbusy_valid", 32'(out_valid), 32'd0);
        chk("rbusy_ready", 32'(in_ready), 32'd1);
        chk("rbusy_flags", {30'd0, flag_e, flag_gt}, 32'd0);
        chk("rbusy_res", aluresult, 32'd0);
        step();
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            step();
            stray = stray | out_valid | !in_ready;
        end
        chk("rbusy_no_stale", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
